snd_dma_seq: RTL and testbench
==============================

# snd_dma_seq

Sound DMA sequencer feeding the MCU control stage: holds the programmed frame start/end word addresses, steps the current sound fetch address on every completed sound load, and tracks shifter sound-FIFO occupancy. It produces the `sndon` and `sreq` levels consumed by the control stage, which returns `sload` when a sound word has been fetched. Frame-end events raise a one-cycle `sint` for the interrupt/timer logic; loop mode replays the frame without CPU intervention.

## Interface
Parameters:
- `ADDR_W`, 21, word-address width (byte address bits 21:1)
- `DEPTH`, 4, sound FIFO depth in words (power of two, ≥2)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_we`  in  1  write strobe for frame start register
- `end_we`  in  1  write strobe for frame end register
- `addr_din`  in  ADDR_W  data for start/end writes
- `ctrl_we`  in  1  write strobe for control register
- `ctrl_din`  in  2  bit0 = enable, bit1 = loop
- `sload`  in  1  one-cycle pulse: one sound word fetched into FIFO
- `stake`  in  1  one-cycle pulse: shifter consumed one word from FIFO
- `sndon`  out  1  sound DMA active
- `sreq`  out  1  FIFO has room, fetch requested
- `snd_addr`  out  ADDR_W  current fetch word address
- `sint`  out  1  one-cycle pulse at frame end
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy
- `ovf`, `unf`  out  1  sticky overflow / underflow flags, cleared by `ctrl_we`

## Operation
- Registers `start_r`, `end_r`, `loop_r`; written any time, values take effect only when latched at frame start (ARM or loop reload).
- States: IDLE, ARM, RUN.
- IDLE: `sndon`=0, `sreq`=0. `ctrl_we` with enable=1 → ARM.
- ARM (1 cycle): `snd_addr`←`start_r`, `end_l`←`end_r`. If `start_r` ≥ `end_r`: `sint` pulse, → IDLE (regardless of loop). Else → RUN, `sndon`=1.
- RUN, on `sload`: `nxt`=`snd_addr`+1 (ADDR_W wrap). If `nxt`==`end_l`: `sint` pulse; loop_r=1 → `snd_addr`←`start_r`, `end_l`←`end_r`, stay RUN; loop_r=0 → IDLE. Else `snd_addr`←`nxt`.
- RUN, `ctrl_we` with enable=0 → IDLE next cycle; a same-cycle `sload` still advances `snd_addr` and may raise `sint`, disable wins state.
- `ctrl_we` with enable=1 in RUN: updates `loop_r` only, no re-arm.
- Level counter (all states): +1 on `sload`, −1 on `stake`, both → unchanged. `sload` at DEPTH: level holds, `ovf`←1. `stake` at 0: level holds, `unf`←1. Level is not cleared on disable (shifter drains).
- `sreq` = RUN && level < DEPTH−1 (registered; one-slot margin covers request latency).

## Timing
- All outputs registered; reset values: `sndon`=0, `sreq`=0, `snd_addr`=0, `sint`=0, `level`=0, `ovf`=`unf`=0; `start_r`=`end_r`=0, `loop_r`=0, state IDLE.
- Enable write at edge n → ARM at n+1 → `sndon`=1, `sreq` valid at n+2.
- `sload` at edge n → `snd_addr`, `level`, `sint` updated at n+1; `sreq` reflects new level at n+1.
- `rst` mid-frame: all state to reset values next edge, registers included.

## Structure
- Package `snd_dma_pkg`: state enum, `CTRL_EN`/`CTRL_LOOP` bit indices, default `ADDR_W`/`DEPTH`.
- Sub-module `snd_level_cnt`: saturating up/down occupancy counter with `ovf`/`unf` flags.

## Test plan
- Reset, start=0x100, end=0x104, enable no loop; 4 `sload` → `snd_addr` 0x100..0x103, `sint` once on 4th, `sndon`=0 after.
- Same with loop=1; 8 `sload` → `sint` twice, `snd_addr` back to 0x100 each time; write end=0x102 mid-frame → second frame 2 words.
- start=0x200, end=0x200, enable → `sint` at ARM+1, IDLE, `sreq` never high.
- DEPTH=4: 3 `sload` no `stake` → `sreq` drops at level 3; 2 more `sload` → level 4 then `ovf`=1; `stake`+`sload` same cycle → level unchanged.
- `stake` at level 0 → `unf`=1, level 0; `ctrl_we` clears flags.
- Disable write coincident with `sload` at end-of-frame → `sint` pulse, IDLE, `snd_addr` reloaded/advanced per loop rule.

Source files
------------

// File: rtl/snd_dma_pkg.sv
// Shared types and defaults for the sound DMA sequencer.
package snd_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_LOOP  = 1;
  localparam int unsigned DEF_ADDR_W = 21;
  localparam int unsigned DEF_DEPTH  = 4;

endpackage

// File: rtl/snd_level_cnt.sv
// Saturating sound-FIFO occupancy counter with sticky overflow/underflow flags.
module snd_level_cnt #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [LW-1:0] level,
  output logic [LW-1:0] level_nxt,
  output logic          ovf,
  output logic          unf
);

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic ovf_set;
  logic unf_set;

  always_comb begin
    level_nxt = level;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (inc && !dec) begin
      if (level == FULL) ovf_set = 1'b1;
      else               level_nxt = level + 1'b1;
    end else if (dec && !inc) begin
      if (level == '0) unf_set = 1'b1;
      else             level_nxt = level - 1'b1;
    end
  end

  // A new event in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      level <= level_nxt;
      ovf   <= (ovf & ~clr) | ovf_set;
      unf   <= (unf & ~clr) | unf_set;
    end
  end

endmodule

// File: rtl/snd_dma_seq.sv
// Sound DMA sequencer: frame address stepping, loop replay, FIFO request and frame-end interrupt.
module snd_dma_seq
  import snd_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_we,
  input  logic                       end_we,
  input  logic [ADDR_W-1:0]          addr_din,
  input  logic                       ctrl_we,
  input  logic [1:0]                 ctrl_din,
  input  logic                       sload,
  input  logic                       stake,
  output logic                       sndon,
  output logic                       sreq,
  output logic [ADDR_W-1:0]          snd_addr,
  output logic                       sint,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] start_r, end_r, end_l;
  logic              loop_r;
  logic [ADDR_W-1:0] step_addr, addr_nxt, end_l_nxt;
  logic [LW-1:0]     level_nxt;
  logic              frame_end, arm_empty, disable_req;
  logic              sint_nxt, sndon_nxt, sreq_nxt;

  snd_level_cnt #(.DEPTH(DEPTH), .LW(LW)) u_level (
    .clk       (clk),
    .rst       (rst),
    .inc       (sload),
    .dec       (stake),
    .clr       (ctrl_we),
    .level     (level),
    .level_nxt (level_nxt),
    .ovf       (ovf),
    .unf       (unf)
  );

  assign step_addr   = snd_addr + 1'b1;
  assign frame_end   = (state == RUN) && sload && (step_addr == end_l);
  assign arm_empty   = (start_r >= end_r);
  assign disable_req = ctrl_we && !ctrl_din[CTRL_EN];

  always_ff @(posedge clk) begin
    if (rst) begin
      start_r <= '0;
      end_r   <= '0;
      loop_r  <= 1'b0;
    end else begin
      if (start_we) start_r <= addr_din;
      if (end_we)   end_r   <= addr_din;
      if (ctrl_we)  loop_r  <= ctrl_din[CTRL_LOOP];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_we && ctrl_din[CTRL_EN]) state_nxt = ARM;
      ARM:     state_nxt = arm_empty ? IDLE : RUN;
      RUN:     if ((frame_end && !loop_r) || disable_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address update follows the loop rule even when a disable lands on the frame-end load.
  always_comb begin
    addr_nxt  = snd_addr;
    end_l_nxt = end_l;
    sint_nxt  = 1'b0;
    if (state == ARM) begin
      addr_nxt  = start_r;
      end_l_nxt = end_r;
      sint_nxt  = arm_empty;
    end else if (state == RUN && sload) begin
      if (frame_end) begin
        sint_nxt = 1'b1;
        if (loop_r) begin
          addr_nxt  = start_r;
          end_l_nxt = end_r;
        end
      end else begin
        addr_nxt = step_addr;
      end
    end
    sndon_nxt = (state_nxt == RUN);
    sreq_nxt  = sndon_nxt && (level_nxt < LW'(DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snd_addr <= '0;
      end_l    <= '0;
      sint     <= 1'b0;
      sndon    <= 1'b0;
      sreq     <= 1'b0;
    end else begin
      snd_addr <= addr_nxt;
      end_l    <= end_l_nxt;
      sint     <= sint_nxt;
      sndon    <= sndon_nxt;
      sreq     <= sreq_nxt;
    end
  end

endmodule

// File: tb/tb_snd_dma_seq.sv
// Directed scoreboard bench for snd_dma_seq (ADDR_W=21, DEPTH=4).
module tb_snd_dma_seq;

  typedef struct packed {
    logic        sndon;
    logic        sreq;
    logic [20:0] addr;
    logic        sint;
    logic [2:0]  level;
    logic        ovf;
    logic        unf;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_we = 1'b0, end_we = 1'b0, ctrl_we = 1'b0;
  logic [20:0] addr_din = '0;
  logic [1:0]  ctrl_din = '0;
  logic        sload = 1'b0, stake = 1'b0;
  logic        sndon, sreq, sint, ovf, unf;
  logic [20:0] snd_addr;
  logic [2:0]  level;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  snd_dma_seq #(.ADDR_W(21), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_we (start_we),
    .end_we   (end_we),
    .addr_din (addr_din),
    .ctrl_we  (ctrl_we),
    .ctrl_din (ctrl_din),
    .sload    (sload),
    .stake    (stake),
    .sndon    (sndon),
    .sreq     (sreq),
    .snd_addr (snd_addr),
    .sint     (sint),
    .level    (level),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic on, input logic rq, input logic [20:0] a,
                              input logic si, input logic [2:0] lv, input logic ov,
                              input logic un);
    return {on, rq, a, si, lv, ov, un};
  endfunction

  task automatic wr_start(input logic [20:0] v);
    start_we = 1'b1;
    addr_din = v;
  endtask

  task automatic wr_end(input logic [20:0] v);
    end_we   = 1'b1;
    addr_din = v;
  endtask

  task automatic wr_ctrl(input logic [1:0] v);
    ctrl_we  = 1'b1;
    ctrl_din = v;
  endtask

  task automatic step(input string tag, input logic sl, input logic st, input obs_t e);
    obs_t  o, x;
    string t;
    sload = sl;
    stake = st;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    o = {sndon, sreq, snd_addr, sint, level, ovf, unf};
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (o === x) else begin
      miscompares++;
      $error("FAIL %s: observed sndon=%0b sreq=%0b addr=%h sint=%0b level=%0d ovf=%0b unf=%0b, expected sndon=%0b sreq=%0b addr=%h sint=%0b level=%0d ovf=%0b unf=%0b",
             t, o.sndon, o.sreq, o.addr, o.sint, o.level, o.ovf, o.unf,
             x.sndon, x.sreq, x.addr, x.sint, x.level, x.ovf, x.unf);
    end
    start_we = 1'b0;
    end_we   = 1'b0;
    ctrl_we  = 1'b0;
    sload    = 1'b0;
    stake    = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step("reset0", 0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));
    step("reset1", 0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));
    rst = 1'b0;

    // Single frame 0x100..0x103, no loop
    wr_start(21'h100); step("wr_start", 0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));
    wr_end(21'h104);   step("wr_end",   0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));
    wr_ctrl(2'b01);    step("enable",   0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));
    step("arm", 0, 0, mk(1, 1, 21'h100, 0, 0, 0, 0));
    for (int i = 1; i <= 3; i++)
      step("nl_load", 1, 1, mk(1, 1, 21'(32'h100 + i), 0, 0, 0, 0));
    step("nl_end",  1, 1, mk(0, 0, 21'h103, 1, 0, 0, 0));
    step("nl_idle", 0, 0, mk(0, 0, 21'h103, 0, 0, 0, 0));

    // Loop mode: two 4-word frames, then shortened end takes effect on next frame
    wr_ctrl(2'b11); step("lp_enable", 0, 0, mk(0, 0, 21'h103, 0, 0, 0, 0));
    step("lp_arm", 0, 0, mk(1, 1, 21'h100, 0, 0, 0, 0));
    for (int f = 0; f < 2; f++) begin
      for (int i = 1; i <= 3; i++)
        step("lp_load", 1, 1, mk(1, 1, 21'(32'h100 + i), 0, 0, 0, 0));
      step("lp_wrap", 1, 1, mk(1, 1, 21'h100, 1, 0, 0, 0));
    end
    for (int i = 1; i <= 3; i++) begin
      if (i == 1) wr_end(21'h102);
      step("lp3_load", 1, 1, mk(1, 1, 21'(32'h100 + i), 0, 0, 0, 0));
    end
    step("lp3_wrap", 1, 1, mk(1, 1, 21'h100, 1, 0, 0, 0));
    step("lp4_load", 1, 1, mk(1, 1, 21'h101, 0, 0, 0, 0));
    step("lp4_wrap", 1, 1, mk(1, 1, 21'h100, 1, 0, 0, 0));

    // Disable coincident with the frame-end load: reload per loop, go idle
    step("lp5_load", 1, 1, mk(1, 1, 21'h101, 0, 0, 0, 0));
    wr_ctrl(2'b00); step("dis_end", 1, 1, mk(0, 0, 21'h100, 1, 0, 0, 0));
    step("dis_idle", 0, 0, mk(0, 0, 21'h100, 0, 0, 0, 0));

    // Empty frame: start == end
    wr_start(21'h200); step("ef_start", 0, 0, mk(0, 0, 21'h100, 0, 0, 0, 0));
    wr_end(21'h200);   step("ef_end",   0, 0, mk(0, 0, 21'h100, 0, 0, 0, 0));
    wr_ctrl(2'b01);    step("ef_enable", 0, 0, mk(0, 0, 21'h100, 0, 0, 0, 0));
    step("ef_arm",  0, 0, mk(0, 0, 21'h200, 1, 0, 0, 0));
    step("ef_idle", 0, 0, mk(0, 0, 21'h200, 0, 0, 0, 0));

    // FIFO level, request margin, overflow and underflow
    wr_start(21'h300); step("lv_start",  0, 0, mk(0, 0, 21'h200, 0, 0, 0, 0));
    wr_end(21'h310);   step("lv_end",    0, 0, mk(0, 0, 21'h200, 0, 0, 0, 0));
    wr_ctrl(2'b01);    step("lv_enable", 0, 0, mk(0, 0, 21'h200, 0, 0, 0, 0));
    step("lv_arm",  0, 0, mk(1, 1, 21'h300, 0, 0, 0, 0));
    step("lv_1",    1, 0, mk(1, 1, 21'h301, 0, 1, 0, 0));
    step("lv_2",    1, 0, mk(1, 1, 21'h302, 0, 2, 0, 0));
    step("lv_3",    1, 0, mk(1, 0, 21'h303, 0, 3, 0, 0));
    step("lv_4",    1, 0, mk(1, 0, 21'h304, 0, 4, 0, 0));
    step("lv_ovf",  1, 0, mk(1, 0, 21'h305, 0, 4, 1, 0));
    step("lv_both", 1, 1, mk(1, 0, 21'h306, 0, 4, 1, 0));
    step("lv_t3",   0, 1, mk(1, 0, 21'h306, 0, 3, 1, 0));
    step("lv_t2",   0, 1, mk(1, 1, 21'h306, 0, 2, 1, 0));
    step("lv_t1",   0, 1, mk(1, 1, 21'h306, 0, 1, 1, 0));
    step("lv_t0",   0, 1, mk(1, 1, 21'h306, 0, 0, 1, 0));
    step("lv_unf",  0, 1, mk(1, 1, 21'h306, 0, 0, 1, 1));
    wr_ctrl(2'b01); step("lv_clr_norearm", 0, 0, mk(1, 1, 21'h306, 0, 0, 0, 0));
    wr_ctrl(2'b00); step("lv_disable",     0, 0, mk(0, 0, 21'h306, 0, 0, 0, 0));
    step("idle_load", 1, 0, mk(0, 0, 21'h306, 0, 1, 0, 0));
    step("idle_take", 0, 1, mk(0, 0, 21'h306, 0, 0, 0, 0));

    // Reset mid-frame clears programmed registers too
    wr_start(21'h400); step("rs_start",  0, 0, mk(0, 0, 21'h306, 0, 0, 0, 0));
    wr_end(21'h410);   step("rs_end",    0, 0, mk(0, 0, 21'h306, 0, 0, 0, 0));
    wr_ctrl(2'b11);    step("rs_enable", 0, 0, mk(0, 0, 21'h306, 0, 0, 0, 0));
    step("rs_arm",  0, 0, mk(1, 1, 21'h400, 0, 0, 0, 0));
    step("rs_load", 1, 0, mk(1, 1, 21'h401, 0, 1, 0, 0));
    rst = 1'b1;
    step("rs_reset", 0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));
    rst = 1'b0;
    wr_ctrl(2'b01); step("rs_enable2", 0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));
    step("rs_arm_empty", 0, 0, mk(0, 0, 21'h0, 1, 0, 0, 0));
    step("rs_idle",      0, 0, mk(0, 0, 21'h0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
